mem_stage_ctrl: RTL

- Sequences the data-memory access for the instruction held in the EXE/MEM pipeline register.
- Inputs are the ALU result (address), rs2 store data and the load/store decode. The block issues one bus transaction per instruction and freezes the pipeline until that transaction completes.
- It forms byte strobes and replicated store data, and returns sign/zero-extended load data to MEM/WB.
- It flags misaligned, illegal-width and timed-out accesses.

---
 rtl/mem_stage_ctrl_if.sv | 21 ++
 rtl/mem_stage_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage controller (master) and the memory (slave).
interface mem_stage_ctrl_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data access sequencer: one bus transaction per EXE/MEM instruction,
// pipeline freeze until completion, store lane formatting and load extension.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_rd,
  input  logic                   mem_wr,
  input  logic [2:0]             funct3,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  mem_stage_ctrl_if.master       dm,
  output logic                   stall,
  output logic [31:0]            ld_data,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dm_req_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          bad;
  logic          tmo;
  dm_req_t       nxt_req;
  logic [31:0]   rd_sh;
  logic [7:0]    rd_b;
  logic [15:0]   rd_h;
  logic [31:0]   ld_ext;

  assign stall = (state == IDLE && (mem_rd || mem_wr)) || state == REQ || state == RESP;
  assign tmo   = cnt >= CW'(TIMEOUT - 1);

  always_comb begin
    bad = 1'b0;
    case (funct3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = addr[0];
      3'b010:         bad = |addr[1:0];
      default:        bad = 1'b1;
    endcase
  end

  always_comb begin
    nxt_req.we   = mem_wr;
    nxt_req.addr = {addr[31:2], 2'b00};
    case (funct3[1:0])
      2'b00: begin
        nxt_req.wstrb = 4'b0001 << addr[1:0];
        nxt_req.wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        nxt_req.wstrb = addr[1] ? 4'b1100 : 4'b0011;
        nxt_req.wdata = {2{wdata[15:0]}};
      end
      default: begin
        nxt_req.wstrb = 4'b1111;
        nxt_req.wdata = wdata;
      end
    endcase
    if (!mem_wr) nxt_req.wstrb = 4'b0000;
  end

  // Byte/half lane selection from the word returned by the bus.
  assign rd_sh = dm.dm_rdata >> {addr[1:0], 3'b000};
  assign rd_b  = rd_sh[7:0];
  assign rd_h  = addr[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];

  always_comb begin
    case (funct3)
      3'b000:  ld_ext = {{24{rd_b[7]}}, rd_b};
      3'b100:  ld_ext = {24'h0, rd_b};
      3'b001:  ld_ext = {{16{rd_h[15]}}, rd_h};
      3'b101:  ld_ext = {16'h0, rd_h};
      default: ld_ext = dm.dm_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wstrb <= '0;
      dm.dm_wdata <= '0;
      ld_data     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (mem_rd || mem_wr) begin
          if (bad) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            state       <= REQ;
            cnt         <= '0;
            dm.dm_req   <= 1'b1;
            dm.dm_we    <= nxt_req.we;
            dm.dm_addr  <= nxt_req.addr;
            dm.dm_wstrb <= nxt_req.wstrb;
            dm.dm_wdata <= nxt_req.wdata;
          end
        end
        REQ: begin
          cnt <= cnt + CW'(1);
          if (dm.dm_gnt) begin
            dm.dm_req <= 1'b0;
            if (dm.dm_we) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RESP;
            end
          end else if (tmo) begin
            dm.dm_req <= 1'b0;
            ld_data   <= '0;
            state     <= DONE;
            done      <= 1'b1;
            err       <= 1'b1;
          end
        end
        RESP: begin
          cnt <= cnt + CW'(1);
          if (dm.dm_rvalid) begin
            ld_data <= ld_ext;
            state   <= DONE;
            done    <= 1'b1;
          end else if (tmo) begin
            ld_data <= '0;
            state   <= DONE;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
